// File: rtl/key_debounce_repeat_if.sv
// key_debounce_repeat_if
//   Bundles the tick enable, raw key, repeat enable and the conditioned
//   key outputs of key_debounce_repeat.
//   master : drives ce, key_raw, repeat_en; observes the outputs
//   slave  : the conditioner itself
//
//   ce         tick enable; all timing is counted in ce-qualified clk edges
//   key_raw    raw asynchronous key, 1 = pressed
//   repeat_en  1 = auto-repeat allowed (sampled on ce)
//   key_level  debounced key level
//   trigger    high for exactly one ce period per press/repeat event
//   strobe     one-clk pulse on the clk edge where trigger rises
//   repeating  high while repeat pulses are being generated
interface key_debounce_repeat_if;
    logic ce;
    logic key_raw;
    logic repeat_en;
    logic key_level;
    logic trigger;
    logic strobe;
    logic repeating;

    modport master (
        output ce, key_raw, repeat_en,
        input  key_level, trigger, strobe, repeating
    );

    modport slave (
        input  ce, key_raw, repeat_en,
        output key_level, trigger, strobe, repeating
    );
endinterface

// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat
//   Key conditioner for OSD/menu keys: synchronises and debounces a raw key,
//   emits a one-ce-period trigger on press, and after DELAY ce ticks emits
//   typematic repeat triggers every RATE ce ticks while the key is held.
//
//   Ports
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    key_debounce_repeat_if.slave
//              ce, key_raw, repeat_en          (in)
//              key_level, trigger, strobe,
//              repeating                       (out)
//
//   Parameters
//     DEBOUNCE  ce ticks of changed input needed to accept a new level (>=1)
//     DELAY     ce ticks from press pulse to first repeat pulse (>=2)
//     RATE      ce ticks between repeat pulses (>=2)
//     CNT_W     delay/rate counter width; DELAY-1 and RATE-1 must fit
module key_debounce_repeat #(
    parameter int DEBOUNCE = 8,
    parameter int DELAY    = 250,
    parameter int RATE     = 50,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    key_debounce_repeat_if.slave  bus
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(RATE - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DELAYING = 2'd1;
    localparam logic [1:0] ST_REPEAT   = 2'd2;

    // Counter step that holds at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    logic             ks_meta;
    logic             ks;
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_cnt_nxt;
    logic             key_level;
    logic             level_nxt;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_nxt;
    logic             trigger;
    logic             trig_nxt;
    logic             strobe;
    logic             strobe_nxt;
    logic             repeating;
    logic             rise;
    logic             fall;

    // Debounce: a new level is accepted only after DEBOUNCE consecutive ce
    // ticks disagreeing with the current level; any agreeing tick restarts.
    always_comb begin
        level_nxt  = key_level;
        db_cnt_nxt = db_cnt;
        if (bus.ce) begin
            if (ks == key_level) begin
                db_cnt_nxt = '0;
            end else if (db_cnt == DB_LAST) begin
                level_nxt  = ks;
                db_cnt_nxt = '0;
            end else begin
                db_cnt_nxt = db_cnt + DB_W'(1);
            end
        end
    end

    // Edges are taken from the level that is being registered this tick so
    // the press pulse lands on the same ce edge as key_level.
    assign rise = level_nxt & ~key_level;
    assign fall = ~level_nxt & key_level;

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        trig_nxt    = trigger;
        if (bus.ce) begin
            trig_nxt = 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rise) begin
                        trig_nxt    = 1'b1;
                        counter_nxt = DELAY_LOAD;
                        state_nxt   = ST_DELAYING;
                    end
                end
                ST_DELAYING: begin
                    if (fall) begin
                        state_nxt = ST_IDLE;
                    end else if (counter != '0) begin
                        counter_nxt = sat_dec(counter);
                    end else if (bus.repeat_en) begin
                        trig_nxt    = 1'b1;
                        counter_nxt = RATE_LOAD;
                        state_nxt   = ST_REPEAT;
                    end
                    // counter==0 with repeat_en low: park here until enabled
                end
                ST_REPEAT: begin
                    if (fall) begin
                        state_nxt = ST_IDLE;
                    end else if (!bus.repeat_en) begin
                        // Park expired in DELAYING so re-enabling fires at once.
                        counter_nxt = '0;
                        state_nxt   = ST_DELAYING;
                    end else if (counter != '0) begin
                        counter_nxt = sat_dec(counter);
                    end else begin
                        trig_nxt    = 1'b1;
                        counter_nxt = RATE_LOAD;
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    counter_nxt = '0;
                end
            endcase
        end
    end

    assign strobe_nxt = bus.ce & trig_nxt & ~trigger;

    // Synchroniser runs every clk; everything after it advances only on ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ks_meta   <= 1'b0;
            ks        <= 1'b0;
            db_cnt    <= '0;
            key_level <= 1'b0;
            state     <= ST_IDLE;
            counter   <= '0;
            trigger   <= 1'b0;
            strobe    <= 1'b0;
            repeating <= 1'b0;
        end else begin
            ks_meta   <= bus.key_raw;
            ks        <= ks_meta;
            db_cnt    <= db_cnt_nxt;
            key_level <= level_nxt;
            state     <= state_nxt;
            counter   <= counter_nxt;
            trigger   <= trig_nxt;
            strobe    <= strobe_nxt;
            repeating <= (state_nxt == ST_REPEAT);
        end
    end

    assign bus.key_level = key_level;
    assign bus.trigger   = trigger;
    assign bus.strobe    = strobe;
    assign bus.repeating = repeating;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// tb_key_debounce_repeat
//   Directed bench for key_debounce_repeat with DEBOUNCE=8, DELAY=5, RATE=3.
//   A segment table drives ce=1 every clk and states the expected outputs
//   for each cycle; hand-written sequences cover async reset mid-repeat and
//   a ce that ticks every 4th clk.
module tb_key_debounce_repeat;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    key_debounce_repeat_if bus ();

    key_debounce_repeat #(
        .DEBOUNCE (8),
        .DELAY    (5),
        .RATE     (3),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic kr;
        logic re;
        int   n;
        logic lvl;
        logic trg;
        logic stb;
        logic rep;
    } seg_t;

    seg_t tbl[$];

    function automatic void add(input logic kr, input logic re, input int n,
                                input logic lvl, input logic trg,
                                input logic stb, input logic rep);
        seg_t s;
        s.kr = kr; s.re = re; s.n = n;
        s.lvl = lvl; s.trg = trg; s.stb = stb; s.rep = rep;
        tbl.push_back(s);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_outs(input string tag, input logic lvl, input logic trg,
                              input logic stb, input logic rep);
        check({tag, ".key_level"}, 32'(bus.key_level), 32'(lvl));
        check({tag, ".trigger"},   32'(bus.trigger),   32'(trg));
        check({tag, ".strobe"},    32'(bus.strobe),    32'(stb));
        check({tag, ".repeating"}, 32'(bus.repeating), 32'(rep));
    endtask

    // Inputs change 1 time unit after a rising edge, outputs are sampled there.
    task automatic cyc(input logic c, input logic kr, input logic re);
        bus.ce        = c;
        bus.key_raw   = kr;
        bus.repeat_en = re;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rises [6];
        int det_cnt;
        logic det_prev;
        logic exp_trg;
        logic exp_stb;

        bus.ce        = 1'b0;
        bus.key_raw   = 1'b0;
        bus.repeat_en = 1'b0;

        #2 reset = 1'b1;
        #2 check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Glitch: 7 cycles high never reaches the 8-tick debounce.
        add(1, 1,  7, 0, 0, 0, 0);
        add(0, 1, 12, 0, 0, 0, 0);
        // Auto-repeat: press t0, repeats t5,8,11,14,17; release accepted at
        // t20 where the due repeat is suppressed by the fall.
        add(1, 1,  9, 0, 0, 0, 0);
        add(1, 1,  1, 1, 1, 1, 0);
        add(1, 1,  4, 1, 0, 0, 0);
        add(1, 1,  1, 1, 1, 1, 1);
        add(1, 1,  2, 1, 0, 0, 1);
        add(1, 1,  1, 1, 1, 1, 1);
        add(1, 1,  2, 1, 0, 0, 1);
        add(0, 1,  1, 1, 1, 1, 1);
        add(0, 1,  2, 1, 0, 0, 1);
        add(0, 1,  1, 1, 1, 1, 1);
        add(0, 1,  2, 1, 0, 0, 1);
        add(0, 1,  1, 1, 1, 1, 1);
        add(0, 1,  2, 1, 0, 0, 1);
        add(0, 1,  1, 0, 0, 0, 0);
        add(0, 1,  3, 0, 0, 0, 0);
        // repeat_en low: only press pulse until enabled at t12, then every 3;
        // dropping repeat_en at t19 halts, raising it at t20 fires at once.
        add(1, 0,  9, 0, 0, 0, 0);
        add(1, 0,  1, 1, 1, 1, 0);
        add(1, 0, 11, 1, 0, 0, 0);
        add(1, 1,  1, 1, 1, 1, 1);
        add(1, 1,  2, 1, 0, 0, 1);
        add(1, 1,  1, 1, 1, 1, 1);
        add(1, 1,  2, 1, 0, 0, 1);
        add(1, 1,  1, 1, 1, 1, 1);
        add(1, 0,  1, 1, 0, 0, 0);
        add(1, 1,  1, 1, 1, 1, 1);
        add(0, 1,  2, 1, 0, 0, 1);
        add(0, 1,  1, 1, 1, 1, 1);
        add(0, 1,  2, 1, 0, 0, 1);
        add(0, 1,  1, 1, 1, 1, 1);
        add(0, 1,  2, 1, 0, 0, 1);
        add(0, 1,  1, 1, 1, 1, 1);
        add(0, 1,  1, 0, 0, 0, 0);
        add(0, 1,  3, 0, 0, 0, 0);
        // Release while DELAYING (parked, repeat_en low): fall at t9, no pulse.
        add(1, 0,  9, 0, 0, 0, 0);
        add(0, 0,  1, 1, 1, 1, 0);
        add(0, 0,  8, 1, 0, 0, 0);
        add(0, 0,  1, 0, 0, 0, 0);
        add(0, 0,  2, 0, 0, 0, 0);
        // Fresh press afterwards.
        add(1, 1,  9, 0, 0, 0, 0);
        add(1, 1,  1, 1, 1, 1, 0);
        add(1, 1,  2, 1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                cyc(1'b1, tbl[i].kr, tbl[i].re);
                check_outs($sformatf("seg%0d.%0d", i, j),
                           tbl[i].lvl, tbl[i].trg, tbl[i].stb, tbl[i].rep);
            end
        end

        // Continue holding into REPEAT, then reset asynchronously while
        // trigger is high.
        cyc(1'b1, 1'b1, 1'b1);
        check_outs("pre_rst.t3", 1, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1);
        check_outs("pre_rst.t4", 1, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1);
        check_outs("pre_rst.t5", 1, 1, 1, 1);
        #2 reset = 1'b1;
        #1 check_outs("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            cyc(1'b1, 1'b1, 1'b1);
            check_outs($sformatf("post_rst.%0d", r),
                       r == 10, r == 10, r == 10, 1'b0);
        end

        // ce every 4th clk: press accepted at clk 32, pulses every ce tick
        // group of 4 clks, release at clk 77 gives a fall at clk 108.
        bus.ce      = 1'b0;
        bus.key_raw = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rises    = '{32, 52, 64, 76, 88, 100};
        det_cnt  = 0;
        det_prev = 1'b0;
        for (int c = 0; c < 140; c++) begin
            cyc((c % 4) == 0, c < 77, 1'b1);
            exp_trg = 1'b0;
            exp_stb = 1'b0;
            foreach (rises[k]) begin
                if (c >= rises[k] && c <= rises[k] + 3) exp_trg = 1'b1;
                if (c == rises[k]) exp_stb = 1'b1;
            end
            check_outs($sformatf("ce4.clk%0d", c), (c >= 32) && (c < 108),
                       exp_trg, exp_stb, (c >= 52) && (c < 108));
            if ((c % 4) == 0) begin
                if (bus.trigger && !det_prev) det_cnt++;
                det_prev = bus.trigger;
            end
        end
        check("ce4.pulse_count", 32'(det_cnt), 32'd6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_debounce_repeat.md
Name: key_debounce_repeat

Overview:
- Upstream conditioner for OSD/menu keys. Debounces a raw asynchronous key input and emits edge-qualified trigger pulses, with typematic auto-repeat.
- Its trigger output drives the one-shot pulse stretcher's trigger input; both blocks share the same clk/ce tick domain.
- Held keys produce an initial press pulse, then after a delay a stream of repeat pulses until release.

Parameters:
- DEBOUNCE, 8: consecutive ce ticks of changed synchronised input required to accept a new key level (>=1).
- DELAY, 250: ce ticks from press pulse to first repeat pulse (>=2).
- RATE, 50: ce ticks between successive repeat pulses (>=2).
- CNT_W, 16: width of delay/rate counter; DELAY-1 and RATE-1 must fit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable / tick; all timing counted in ce-qualified clk edges
- key_raw  in  1  raw key, asynchronous, active-high = pressed
- repeat_en  in  1  1 = auto-repeat allowed; sampled on ce
- key_level  out  1  debounced key level
- trigger  out  1  pulse level, high for exactly one ce period per event
- strobe  out  1  one-clk pulse on the clk edge where trigger rises (ce-qualified)
- repeating  out  1  high while in REPEAT state

Behaviour:
- Reset (async, active-high): sync flops=0, key_level=0, debounce cnt=0, state=IDLE, counter=0, trigger=0, strobe=0, repeating=0. Release resumes cleanly on the next ce.
- Synchroniser: two flops on key_raw, clocked every clk (not gated by ce). Output = ks.
- Debounce, on ce only:
  - ks==key_level: cnt<=0.
  - Otherwise cnt<=cnt+1. When cnt==DEBOUNCE-1, key_level<=ks and cnt<=0.
  - A glitch shorter than DEBOUNCE ce ticks never changes key_level. Any ce tick with ks==key_level restarts the count.
- FSM, states IDLE, DELAYING, REPEAT; evaluated only when ce=1. Here rise/fall = key_level changing at this same ce tick (internal next-value compare).
  - IDLE: on rise -> trigger<=1, counter<=DELAY-1, -> DELAYING. Else trigger<=0.
  - DELAYING: trigger<=0. Fall -> IDLE. Else if counter!=0, counter--. Else if counter==0 and repeat_en=1 -> trigger<=1, counter<=RATE-1, -> REPEAT. Else if counter==0 and repeat_en=0 -> hold (stay, no pulse).
  - REPEAT: trigger<=0 by default. Fall -> IDLE. Else if counter!=0, counter--. Else trigger<=1, counter<=RATE-1. repeat_en=0 in REPEAT -> DELAYING with counter=0 (repeats halt; they resume on repeat_en=1).
- Fall (release) always forces trigger<=0 at that ce tick and state IDLE, regardless of state.
- Timing:
  - Press pulse rises on the ce tick key_level goes 1.
  - First repeat rises exactly DELAY ce ticks later; subsequent repeats every RATE ce ticks.
  - trigger is high exactly one ce period. With DELAY, RATE >=2 it is low for >=1 ce period between pulses, so a ce-sampling rising-edge detector sees every pulse.
- strobe = ce & (trigger next-value rising), registered; width exactly one clk.
- repeating = (state==REPEAT), registered.
- ce=0: FSM, counters, key_level, trigger frozen; strobe=0.
- Counter arithmetic: unsigned CNT_W, never decrements below 0.
- Simultaneous events: rise and counter expiry cannot coincide (rise only from IDLE). Fall takes priority over expiry.

Test Plan:
- Reset mid-REPEAT with trigger=1: assert reset asynchronously -> all outputs 0 immediately, no clk needed. After release, key still held -> press pulse after DEBOUNCE ce ticks.
- Glitch rejection, DEBOUNCE=8, ce every clk: key_raw high for 7 cycles then low -> key_level stays 0, no trigger. High for 10 cycles -> key_level=1 at 8 ce after synchroniser, one trigger pulse.
- Auto-repeat, DELAY=5, RATE=3, repeat_en=1, key held for 20 ce ticks after key_level=1 -> trigger rises at ticks 0, 5, 8, 11, 14, 17, each high 1 tick. repeating=1 from tick 5.
- repeat_en=0 while held 20 ticks -> only the tick-0 pulse. Raise repeat_en at tick 12 -> next pulse at tick 12, then every 3.
- Release during DELAYING, DELAY=5: release so key_level falls at tick 3 -> no further pulses, state IDLE, repeating=0. Re-press yields a fresh press pulse.
- ce=1 every 4th clk: verify each trigger pulse spans exactly 4 clks, strobe is 1 clk wide coincident with ce, and a ce-sampling rising-edge detector counts pulses equal to the expected count (6 in scenario 3).
